// File: rtl/alu_operand_stack_pkg.sv
// Shared stack op encodings and operand requirements for the stack decoder and ALU control.
package alu_operand_stack_pkg;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_POP2    = 3'b011;
  localparam logic [2:0] OP_REPLACE = 3'b100;
  localparam logic [2:0] OP_REDUCE  = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;

  // Minimum occupied entries an op consumes before it may execute.
  function automatic logic [1:0] op_need(input logic [2:0] op);
    case (op)
      OP_POP, OP_REPLACE: op_need = 2'd1;
      OP_POP2, OP_REDUCE: op_need = 2'd2;
      default:            op_need = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_stack_regfile.sv
// Stack storage: one synchronous write port, two asynchronous read ports, no reset.
module alu_operand_stack_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr_a,
  input  logic [PTR_W-1:0] raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_operand_stack.sv
// Operand stack: count, sticky flags, legality checks and address generation around the regfile.
module alu_operand_stack
  import alu_operand_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = PTR_W + 1;
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [CW-1:0]    cnt_m1, cnt_m2;
  logic             we;
  logic [PTR_W-1:0] waddr;
  logic [WIDTH-1:0] rd_tos, rd_nos;
  logic             enough;

  assign cnt_m1 = count_q - CW'(1);
  assign cnt_m2 = count_q - CW'(2);
  assign enough = count_q >= CW'(op_need(op));

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = cnt_m1[PTR_W-1:0];
    case (op)
      OP_PUSH: begin
        if (count_q != CNT_DEPTH) begin
          we      = 1'b1;
          waddr   = count_q[PTR_W-1:0];
          count_d = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_POP: begin
        if (enough) count_d = cnt_m1;
        else        unf_d   = 1'b1;
      end
      OP_POP2: begin
        if (enough) count_d = cnt_m2;
        else        unf_d   = 1'b1;
      end
      OP_REPLACE: begin
        if (enough) we    = 1'b1;
        else        unf_d = 1'b1;
      end
      // The ALU result lands in the old nos slot, which becomes the new top.
      OP_REDUCE: begin
        if (enough) begin
          we      = 1'b1;
          waddr   = cnt_m2[PTR_W-1:0];
          count_d = cnt_m1;
        end else begin
          unf_d = 1'b1;
        end
      end
      OP_CLEAR: begin
        count_d = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  alu_operand_stack_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_regfile (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (din),
    .raddr_a (cnt_m1[PTR_W-1:0]),
    .raddr_b (cnt_m2[PTR_W-1:0]),
    .rdata_a (rd_tos),
    .rdata_b (rd_nos)
  );

  // Unoccupied slots hold stale data, so gate reads by occupancy.
  assign tos       = (count_q != '0)       ? rd_tos : '0;
  assign nos       = (count_q >= CW'(2))   ? rd_nos : '0;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_DEPTH);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_alu_operand_stack.sv
// Randomized bench for alu_operand_stack against a queue-based stack model.
module tb_alu_operand_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       op = 3'b000;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] tos, nos;
  logic [PTR_W:0]   count;
  logic             empty, full, overflow, underflow;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] mq[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  alu_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .din(din),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_tos();
    return (mq.size() >= 1) ? mq[mq.size()-1] : '0;
  endfunction

  function automatic logic [WIDTH-1:0] m_nos();
    return (mq.size() >= 2) ? mq[mq.size()-2] : '0;
  endfunction

  task automatic model_apply(input logic [2:0] o, input logic [WIDTH-1:0] d);
    case (o)
      3'd1: if (mq.size() < DEPTH) mq.push_back(d); else m_ovf = 1;
      3'd2: if (mq.size() >= 1) void'(mq.pop_back()); else m_unf = 1;
      3'd3: if (mq.size() >= 2) begin void'(mq.pop_back()); void'(mq.pop_back()); end
            else m_unf = 1;
      3'd4: if (mq.size() >= 1) mq[mq.size()-1] = d; else m_unf = 1;
      3'd5: if (mq.size() >= 2) begin void'(mq.pop_back()); mq[mq.size()-1] = d; end
            else m_unf = 1;
      3'd6: begin mq.delete(); m_ovf = 0; m_unf = 0; end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; the model follows each edge.
  task automatic step(input logic [2:0] o, input logic [WIDTH-1:0] d);
    op  = o;
    din = d;
    @(posedge clk);
    model_apply(o, d);
    #1;
  endtask

  always @(negedge clk) begin
    check("cmp_count", 32'(count), 32'(mq.size()));
    check("cmp_tos", 32'(tos), 32'(m_tos()));
    check("cmp_nos", 32'(nos), 32'(m_nos()));
    check("cmp_empty", 32'(empty), 32'(mq.size() == 0));
    check("cmp_full", 32'(full), 32'(mq.size() == DEPTH));
    check("cmp_overflow", 32'(overflow), 32'(m_ovf));
    check("cmp_underflow", 32'(underflow), 32'(m_unf));
  end

  initial begin
    logic [WIDTH-1:0] last, second;
    logic [2:0] ro;

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_tos", 32'(tos), 32'd0);
    check("rst_nos", 32'(nos), 32'd0);
    check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    rst_n = 1'b1;

    step(3'd1, 16'h0003);
    step(3'd1, 16'h0005);
    check("push2_tos", 32'(tos), 32'h5);
    check("push2_nos", 32'(nos), 32'h3);
    check("push2_count", 32'(count), 32'd2);

    step(3'd5, 16'h0008);
    check("reduce_tos", 32'(tos), 32'h8);
    check("reduce_nos", 32'(nos), 32'h0);
    check("reduce_count", 32'(count), 32'd1);

    step(3'd3, 16'h0000);
    check("pop2_unf", 32'(underflow), 32'd1);
    check("pop2_count", 32'(count), 32'd1);
    check("pop2_tos", 32'(tos), 32'h8);

    step(3'd6, 16'h0000);
    check("clear_flags", {30'd0, overflow, underflow}, 32'd0);
    check("clear_empty", 32'(empty), 32'd1);

    last = '0;
    for (int i = 0; i < DEPTH; i++) begin
      last = WIDTH'($urandom);
      step(3'd1, last);
    end
    step(3'd1, 16'hFFFF);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_tos", 32'(tos), 32'(last));

    step(3'd6, 16'h0000);
    step(3'd1, 16'h1111);
    second = WIDTH'($urandom);
    step(3'd1, second);
    step(3'd1, 16'h3333);
    step(3'd4, 16'h1234);
    check("repl_tos", 32'(tos), 32'h1234);
    check("repl_nos", 32'(nos), 32'(second));
    check("repl_count", 32'(count), 32'd3);

    // Random phases: push-heavy to reach full, then pop-heavy to hit underflow.
    for (int i = 0; i < 3000; i++) begin
      ro = 3'($urandom_range(0, 7));
      if (ro == 3'd6 && $urandom_range(0, 15) != 0) ro = 3'd1;
      if (i < 1500 && ro == 3'd2 && $urandom_range(0, 1) == 0) ro = 3'd1;
      if (i >= 1500 && ro == 3'd1 && $urandom_range(0, 1) == 0) ro = 3'd3;
      step(ro, WIDTH'($urandom));
    end

    step(3'd6, 16'h0000);
    for (int i = 0; i < 5; i++) step(3'd1, WIDTH'($urandom));
    check("pre_arst_count", 32'(count), 32'd5);
    op = 3'd0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_tos", 32'(tos), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3'd1, 16'hABCD);
    check("post_arst_tos", 32'(tos), 32'hABCD);
    step(3'd0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
